// File: rtl/x2_lane_sequencer_if.sv
// Producer/consumer handshake bundle for the lane sequencer.
// The sequencer connects through the slave modport; the driving side uses master.
interface x2_lane_sequencer_if #(
   parameter int WIDTH = 100
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/x2_lane_sequencer.sv
// Time-multiplexed scale-by-constant window: shifts in one word, then sweeps
// every lane through a single shared multiplier before presenting the last lane.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a word; in_ready high
// S_SWEEP | scaling window[lane_idx] by FACTOR, one lane per cycle
// S_EMIT  | out_valid high, window[LANES-1] held until out_ready
module x2_lane_sequencer #(
   parameter int WIDTH  = 100,
   parameter int LANES  = 10,
   parameter int FACTOR = 2,
   localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   x2_lane_sequencer_if.slave     bus,
   output logic                   busy,
   output logic [IW-1:0]          lane_idx
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_EMIT  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] FACTOR_W  = WIDTH'(FACTOR);
   localparam logic [IW-1:0]    LAST_LANE = IW'(LANES - 1);

   state_t           state_q, state_d;
   logic [IW-1:0]    lane_q, lane_d;
   logic [WIDTH-1:0] win_q [LANES];
   logic [WIDTH-1:0] prod;
   logic             accept;
   logic             sweep_we;
   logic             in_ready_c;
   logic             out_valid_c;

   // The one shared multiplier; the product is truncated to WIDTH bits.
   assign prod = win_q[lane_q] * FACTOR_W;

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      sweep_we    = 1'b0;
      case (state_q)
         S_IDLE: in_ready_c = 1'b1;
         S_SWEEP: begin
            sweep_we = 1'b1;
            if (lane_q == LAST_LANE) begin
               state_d = S_EMIT;
               lane_d  = '0;
            end else begin
               lane_d = lane_q + IW'(1);
            end
         end
         S_EMIT: begin
            out_valid_c = 1'b1;
            in_ready_c  = bus.out_ready;
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_c = in_ready_c && rst && !clear;
      accept     = bus.in_valid && in_ready_c;
      if (accept) begin
         state_d = S_SWEEP;
         lane_d  = '0;
      end
      // A flush wins over every handshake and drops a pending result.
      if (clear) begin
         state_d     = S_IDLE;
         lane_d      = '0;
         out_valid_c = 1'b0;
         sweep_we    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LANES; i++) win_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < LANES; i++) win_q[i] <= '0;
      end else if (accept) begin
         win_q[0] <= bus.in_data;
         for (int i = 1; i < LANES; i++) win_q[i] <= win_q[i-1];
      end else if (sweep_we) begin
         win_q[lane_q] <= prod;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = win_q[LANES-1];
   assign busy          = (state_q != S_IDLE);
   assign lane_idx      = lane_q;

endmodule

// File: tb/tb_x2_lane_sequencer.sv
// Bench for x2_lane_sequencer: directed scenarios with literal expectations plus
// a randomized run, all cross-checked every cycle against a step-level model.
module tb_x2_lane_sequencer;
   localparam int W  = 100;
   localparam int L  = 10;
   localparam int F  = 2;
   localparam int IW = $clog2(L);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clear = 1'b0;
   logic busy;
   logic [IW-1:0] lane_idx;

   x2_lane_sequencer_if #(.WIDTH(W)) bus ();

   x2_lane_sequencer #(.WIDTH(W), .LANES(L), .FACTOR(F)) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .bus      (bus.slave),
      .busy     (busy),
      .lane_idx (lane_idx)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Step-level model: pre = window right after the shift, post = window after
   // the whole step has been scaled. mode 0 idle, 1 sweeping, 2 emitting.
   int m_mode;
   int m_k;
   logic [W-1:0] m_pre  [L];
   logic [W-1:0] m_post [L];

   task automatic model_reset();
      m_mode = 0;
      m_k    = 0;
      for (int i = 0; i < L; i++) begin
         m_pre[i]  = '0;
         m_post[i] = '0;
      end
   endtask

   task automatic model_accept(input logic [W-1:0] d);
      for (int i = L - 1; i >= 1; i--) m_pre[i] = m_post[i-1];
      m_pre[0] = d;
      for (int i = 0; i < L; i++) m_post[i] = m_pre[i] * W'(F);
      m_mode = 1;
      m_k    = 0;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset();
      end else if (clear) begin
         model_reset();
      end else begin
         case (m_mode)
            0: if (bus.in_valid) model_accept(bus.in_data);
            1: begin
               m_k++;
               if (m_k == L) begin
                  m_mode = 2;
                  m_k    = 0;
               end
            end
            default: if (bus.out_ready) begin
               if (bus.in_valid) model_accept(bus.in_data);
               else m_mode = 0;
            end
         endcase
      end
   end

   // Every cycle out of reset the outputs must agree with the model.
   always @(negedge clk) begin
      if (rst) begin
         chk("m_in_ready",  bus.in_ready,
             W'(!clear && (m_mode == 0 || (m_mode == 2 && bus.out_ready))));
         chk("m_out_valid", bus.out_valid, W'(m_mode == 2 && !clear));
         chk("m_busy",      busy, W'(m_mode != 0));
         chk("m_lane_idx",  lane_idx, W'((m_mode == 1) ? m_k : 0));
         chk("m_out_data",  bus.out_data, (m_mode == 1) ? m_pre[L-1] : m_post[L-1]);
         chk("m_win0",      dut.win_q[0], (m_mode == 1 && m_k == 0) ? m_pre[0] : m_post[0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!bus.out_valid && n < budget) begin
         tick();
         n++;
      end
      chk("wait_valid", bus.out_valid, 1);
   endtask

   logic [W-1:0] outs [16];
   int           acc_t [16];

   // Streams nacc words with out_ready held high, recording results and accept cycles.
   task automatic stream(input int nacc, input logic [W-1:0] w_first, input logic [W-1:0] w_rest);
      int na = 0;
      int no = 0;
      int c  = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = w_first;
      while (no < nacc && c < 400) begin
         #1;
         if (bus.in_valid && bus.in_ready && na < 16) begin
            acc_t[na] = c;
            na++;
         end
         if (bus.out_valid && no < 16) begin
            outs[no] = bus.out_data;
            no++;
         end
         tick();
         c++;
         bus.in_data = w_rest;
         if (na >= nacc) bus.in_valid = 1'b0;
      end
      chk("stream_done", W'(no), W'(nacc));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int n;
      logic ir_bad;
      logic [W-1:0] big;
      logic [127:0] rnd;

      model_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_in_ready",  bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_lane_idx",  lane_idx, 0);
      chk("rst_out_data",  bus.out_data, 0);

      // First word: latency and lane-0 scaling.
      bus.in_valid = 1'b1;
      bus.in_data  = W'(5);
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      ir_bad = 1'b0;
      while (!bus.out_valid && n < 50) begin
         if (bus.in_ready) ir_bad = 1'b1;
         tick();
         n++;
      end
      chk("t1_latency",  W'(n), W'(10));
      chk("t1_out_data", bus.out_data, 0);
      chk("t1_ready_sweep", W'(ir_bad), 0);
      chk("t1_win0",     dut.win_q[0], W'(10));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("t1_idle", busy, 0);

      // Eleven ones back-to-back.
      do_clear();
      stream(11, W'(1), W'(1));
      for (int i = 0; i < 9; i++) chk("t2_out_zero", outs[i], 0);
      chk("t2_out10", outs[9], W'(1024));
      chk("t2_out11", outs[10], W'(1024));
      for (int i = 1; i < 11; i++) chk("t2_spacing", W'(acc_t[i] - acc_t[i-1]), W'(11));

      // Wrap-around of the top bit.
      do_clear();
      big = '0;
      big[99] = 1'b1;
      stream(1, big, '0);
      chk("t3_win0_wrap", dut.win_q[0], 0);
      stream(9, '0, '0);
      chk("t3_out10", outs[8], 0);

      // Backpressure in EMIT.
      do_clear();
      bus.in_valid  = 1'b1;
      bus.in_data   = W'(9);
      bus.out_ready = 1'b0;
      wait_valid(50);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_data",  bus.out_data, 0);
         chk("t4_hold_ready", bus.in_ready, 0);
         chk("t4_hold_valid", bus.out_valid, 1);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("t4_ready_release", bus.in_ready, 1);
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("t4_restart_lane", lane_idx, 0);
      chk("t4_restart_busy", busy, 1);
      chk("t4_restart_valid", bus.out_valid, 0);
      wait_valid(20);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // Reset in the middle of a sweep.
      do_clear();
      bus.in_valid = 1'b1;
      bus.in_data  = W'(77);
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (lane_idx != IW'(4) && n < 20) begin
         tick();
         n++;
      end
      chk("t5_lane4", lane_idx, W'(4));
      rst = 1'b0;
      #1;
      chk("t5_rst_valid", bus.out_valid, 0);
      chk("t5_rst_busy",  busy, 0);
      chk("t5_rst_lane",  lane_idx, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("t5_ready_after", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(3);
      tick();
      bus.in_valid = 1'b0;
      wait_valid(20);
      chk("t5_out_data", bus.out_data, 0);
      chk("t5_win0", dut.win_q[0], W'(6));
      chk("t5_win1_lost", dut.win_q[1], 0);

      // Flush while a result is pending and a new word is offered.
      bus.in_valid  = 1'b1;
      bus.in_data   = W'(5);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      wait_valid(20);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = W'(8);
      clear         = 1'b1;
      #1;
      chk("t6_clr_ready", bus.in_ready, 0);
      chk("t6_clr_valid", bus.out_valid, 0);
      tick();
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("t6_idle",      busy, 0);
      chk("t6_win1_zero", dut.win_q[1], 0);
      chk("t6_win0_zero", dut.win_q[0], 0);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(7);
      tick();
      bus.in_valid = 1'b0;
      wait_valid(20);
      chk("t6_out_data", bus.out_data, 0);
      chk("t6_win0",     dut.win_q[0], W'(14));
      bus.out_ready = 1'b1;
      tick();

      // Randomized traffic with occasional flushes and resets.
      for (int c = 0; c < 4000; c++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         bus.in_valid  = ($urandom_range(3) != 0);
         bus.in_data   = ($urandom_range(3) == 0) ? W'($urandom_range(7)) : rnd[W-1:0];
         bus.out_ready = ($urandom_range(2) != 0);
         clear         = ($urandom_range(63) == 0);
         if ($urandom_range(499) == 0) begin
            rst = 1'b0;
            #2;
            rst = 1'b1;
         end
         tick();
      end
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
